// File: rtl/fxp_mult_arbiter_if.sv
// Request/result bundle between the requesting engines and the shared
// fixed-point multiplier.
//
// Handshake: req[i] is the valid of requester i and must stay high with
// op_a[i]/op_b[i] stable until ack[i] is seen. ack[i] is the combinational
// ready. An operation transfers on the rising clk edge where req[i], ack[i]
// and clk_en are all high. Results use no handshake. res_valid[i] is a
// one-hot pulse, one enabled cycle wide, with no back-pressure. busy reports
// operations still inside the pipeline.
interface fxp_mult_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 3
);
    logic [NREQ-1:0]  req;
    logic [WIDTH-1:0] op_a [0:NREQ-1];
    logic [WIDTH-1:0] op_b [0:NREQ-1];
    logic [NREQ-1:0]  ack;
    logic [WIDTH-1:0] res;
    logic [NREQ-1:0]  res_valid;
    logic             res_sat;
    logic             busy;

    // Requester side.
    modport master (
        output req, op_a, op_b,
        input  ack, res, res_valid, res_sat, busy
    );

    // Multiplier side.
    modport slave (
        input  req, op_a, op_b,
        output ack, res, res_valid, res_sat, busy
    );
endinterface

// File: rtl/fxp_mult_arbiter.sv
// Shared signed fixed-point multiplier with a round-robin front end.
// One operation is accepted per enabled cycle. It is tagged with the
// requester ID and returned LAT enabled cycles later as a scaled, saturated
// product with a one-hot valid.
module fxp_mult_arbiter #(
    parameter int WIDTH     = 16,
    parameter int intDigits = 8,
    parameter int NREQ      = 3,
    parameter int LAT       = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    fxp_mult_arbiter_if.slave  bus
);

    localparam int F  = WIDTH - intDigits;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Registers between stage 0 and the output register.
    localparam int D  = (LAT >= 2) ? LAT - 2 : 0;

    localparam logic signed [2*WIDTH-1:0] SMAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] SMIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    // Full-width product, arithmetic shift (floor), then clamp.
    // The return value is {saturated, result}.
    function automatic logic [WIDTH:0] sat_mul(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] p;
        logic signed [2*WIDTH-1:0] s;
        p = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        s = p >>> F;
        if (s > SMAX)      sat_mul = {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
        else if (s < SMIN) sat_mul = {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
        else               sat_mul = {1'b0, s[WIDTH-1:0]};
    endfunction

    logic [PW-1:0]    r_ptr;
    logic [NREQ-1:0]  w_ack;
    logic [PW-1:0]    w_gnt_id;
    logic             w_gnt_v;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;

    logic [WIDTH-1:0] w_head_res;
    logic             w_head_sat;
    logic [PW-1:0]    w_head_id;
    logic             w_head_v;
    logic             w_head_busy;

    logic [WIDTH-1:0] w_tail_res;
    logic             w_tail_sat;
    logic [PW-1:0]    w_tail_id;
    logic             w_tail_v;
    logic             w_mid_busy;

    logic [WIDTH-1:0] r_res;
    logic             r_res_sat;
    logic [NREQ-1:0]  r_res_valid;

    // Round-robin scan from r_ptr. The grant is suppressed in reset or stall.
    always_comb begin
        w_ack    = '0;
        w_gnt_id = '0;
        w_gnt_v  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!w_gnt_v && bus.req[idx]) begin
                w_gnt_v  = 1'b1;
                w_gnt_id = PW'(idx);
            end
        end
        if (!clk_en || !reset) w_gnt_v = 1'b0;
        if (w_gnt_v) w_ack[w_gnt_id] = 1'b1;
    end

    assign w_sel_a = bus.op_a[w_gnt_id];
    assign w_sel_b = bus.op_b[w_gnt_id];

    // Pointer moves past the granted requester on each accepted edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (clk_en && w_gnt_v) begin
            r_ptr <= (w_gnt_id == PW'(NREQ - 1)) ? '0 : w_gnt_id + PW'(1);
        end
    end

    generate
        if (LAT == 1) begin : g_head_direct
            // Single stage: the multiply feeds the output register directly.
            assign {w_head_sat, w_head_res} = sat_mul(w_sel_a, w_sel_b);
            assign w_head_id   = w_gnt_id;
            assign w_head_v    = w_gnt_v;
            assign w_head_busy = 1'b0;
        end else begin : g_head_stage0
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic [PW-1:0]    r_id;
            logic             r_v0;

            // Stage 0 captures the granted operands and the owner tag.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_a  <= '0;
                    r_b  <= '0;
                    r_id <= '0;
                    r_v0 <= 1'b0;
                end else if (clk_en) begin
                    r_v0 <= w_gnt_v;
                    if (w_gnt_v) begin
                        r_a  <= w_sel_a;
                        r_b  <= w_sel_b;
                        r_id <= w_gnt_id;
                    end
                end
            end

            assign {w_head_sat, w_head_res} = sat_mul(r_a, r_b);
            assign w_head_id   = r_id;
            assign w_head_v    = r_v0;
            assign w_head_busy = r_v0;
        end

        if (D == 0) begin : g_mid_none
            assign w_tail_res = w_head_res;
            assign w_tail_sat = w_head_sat;
            assign w_tail_id  = w_head_id;
            assign w_tail_v   = w_head_v;
            assign w_mid_busy = 1'b0;
        end else begin : g_mid_chain
            logic [WIDTH-1:0] r_m_res [D];
            logic [PW-1:0]    r_m_id  [D];
            logic [D-1:0]     r_m_sat;
            logic [D-1:0]     r_m_v;

            // Delay chain that carries the result and tag to reach LAT.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int j = 0; j < D; j++) begin
                        r_m_res[j] <= '0;
                        r_m_id[j]  <= '0;
                    end
                    r_m_sat <= '0;
                    r_m_v   <= '0;
                end else if (clk_en) begin
                    r_m_res[0] <= w_head_res;
                    r_m_id[0]  <= w_head_id;
                    r_m_sat[0] <= w_head_sat;
                    r_m_v[0]   <= w_head_v;
                    for (int j = 1; j < D; j++) begin
                        r_m_res[j] <= r_m_res[j-1];
                        r_m_id[j]  <= r_m_id[j-1];
                        r_m_sat[j] <= r_m_sat[j-1];
                        r_m_v[j]   <= r_m_v[j-1];
                    end
                end
            end

            assign w_tail_res = r_m_res[D-1];
            assign w_tail_sat = r_m_sat[D-1];
            assign w_tail_id  = r_m_id[D-1];
            assign w_tail_v   = r_m_v[D-1];
            assign w_mid_busy = |r_m_v;
        end
    endgenerate

    // Output stage. The one-hot valid is decoded from the tag, and data is zero when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_res       <= '0;
            r_res_sat   <= 1'b0;
            r_res_valid <= '0;
        end else if (clk_en) begin
            r_res       <= '0;
            r_res_sat   <= 1'b0;
            r_res_valid <= '0;
            if (w_tail_v) begin
                r_res                  <= w_tail_res;
                r_res_sat              <= w_tail_sat;
                r_res_valid[w_tail_id] <= 1'b1;
            end
        end
    end

    assign bus.ack       = w_ack;
    assign bus.res       = r_res;
    assign bus.res_sat   = r_res_sat;
    assign bus.res_valid = r_res_valid;
    assign bus.busy      = w_head_busy | w_mid_busy;

endmodule

// File: tb/tb_fxp_mult_arbiter.sv
// Directed bench for fxp_mult_arbiter (WIDTH=16, Q8.8, NREQ=3, LAT=3).
module tb_fxp_mult_arbiter;

    localparam int WIDTH = 16;
    localparam int INTD  = 8;
    localparam int F     = WIDTH - INTD;
    localparam int NREQ  = 3;
    localparam int LAT   = 3;
    // Queue entry: {due enabled cycle[15:0], one-hot owner, sat, res}
    localparam int QW    = 16 + NREQ + 1 + WIDTH;
    localparam int LW    = NREQ + WIDTH + 2;

    logic clk;
    logic reset;
    logic clk_en;

    fxp_mult_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    fxp_mult_arbiter #(
        .WIDTH(WIDTH), .intDigits(INTD), .NREQ(NREQ), .LAT(LAT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .bus    (bus)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [QW-1:0]    exp_q [$];
    int               n_checks;
    int               n_errors;
    int               en_cyc;
    int               m_ptr;
    bit               prev_en;
    logic [LW-1:0]    last;
    bit               pin_v   [NREQ];
    logic [WIDTH-1:0] pin_res [NREQ];
    bit               pin_sat [NREQ];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference multiply in 64-bit integer arithmetic.
    function automatic logic [WIDTH:0] model_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        longint pa, pb, s, hi, lo;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        s  = (pa * pb) >>> F;
        hi = (longint'(1) <<< (WIDTH - 1)) - 1;
        lo = -hi - 1;
        if (s > hi)      return {1'b1, WIDTH'(hi)};
        else if (s < lo) return {1'b1, WIDTH'(lo)};
        else             return {1'b0, s[WIDTH-1:0]};
    endfunction

    // One clock cycle. Outputs are sampled at negedge: results are popped and
    // compared, busy and ack are checked, and accepts are pushed.
    task automatic tick();
        logic [NREQ-1:0]  e_ack;
        logic [QW-1:0]    ent;
        logic [WIDTH:0]   r;
        bit               e_busy;
        int               g;
        @(negedge clk);
        if (prev_en) begin
            if (bus.res_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_res", 64'(bus.res_valid), 64'(0));
                end else begin
                    ent = exp_q.pop_front();
                    chk("res_valid", 64'(bus.res_valid), 64'(ent[WIDTH+NREQ:WIDTH+1]));
                    chk("res",       64'(bus.res),       64'(ent[WIDTH-1:0]));
                    chk("res_sat",   64'(bus.res_sat),   64'(ent[WIDTH]));
                    chk("latency",   64'(en_cyc),        64'(ent[QW-1 -: 16]));
                end
            end else if (exp_q.size() > 0 && int'(exp_q[0][QW-1 -: 16]) <= en_cyc) begin
                ent = exp_q.pop_front();
                chk("missing_res", 64'(bus.res_valid), 64'(ent[WIDTH+NREQ:WIDTH+1]));
            end
        end else begin
            chk("frozen_out", 64'({bus.res_valid, bus.res_sat, bus.res, bus.busy}), 64'(last));
        end
        e_busy = 1'b0;
        foreach (exp_q[i]) if (int'(exp_q[i][QW-1 -: 16]) > en_cyc) e_busy = 1'b1;
        chk("busy", 64'(bus.busy), 64'(e_busy));
        e_ack = '0;
        g = -1;
        if (clk_en && reset) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && bus.req[idx]) g = idx;
            end
        end
        if (g >= 0) e_ack = NREQ'(1) << g;
        chk("ack", 64'(bus.ack), 64'(e_ack));
        if (g >= 0) begin
            if (pin_v[g]) begin
                r = {pin_sat[g], pin_res[g]};
                pin_v[g] = 1'b0;
            end else begin
                r = model_mul(bus.op_a[g], bus.op_b[g]);
            end
            exp_q.push_back({16'(en_cyc + LAT), e_ack, r});
            m_ptr = (g + 1) % NREQ;
        end
        last = {bus.res_valid, bus.res_sat, bus.res, bus.busy};
        @(posedge clk);
        prev_en = clk_en && reset;
        if (clk_en && reset) en_cyc++;
        #1;
    endtask

    // Driver: a single requester issues one operation with a known answer.
    task automatic op(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] er, input bit es);
        bus.op_a[id] = a;
        bus.op_b[id] = b;
        pin_v[id]    = 1'b1;
        pin_res[id]  = er;
        pin_sat[id]  = es;
        bus.req      = NREQ'(1) << id;
        tick();
        bus.req      = '0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            bus.op_a[i] = WIDTH'($urandom_range(0, 65535));
            bus.op_b[i] = WIDTH'($urandom_range(0, 65535));
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        en_cyc   = 0;
        m_ptr    = 0;
        prev_en  = 1'b0;
        last     = '0;
        for (int i = 0; i < NREQ; i++) begin
            pin_v[i] = 1'b0;
            bus.op_a[i] = '0;
            bus.op_b[i] = '0;
        end
        reset   = 1'b0;
        clk_en  = 1'b1;
        bus.req = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        // Reset state.
        chk("rst_res",       64'(bus.res),       64'(0));
        chk("rst_res_valid", 64'(bus.res_valid), 64'(0));
        chk("rst_res_sat",   64'(bus.res_sat),   64'(0));
        chk("rst_busy",      64'(bus.busy),      64'(0));
        chk("rst_ack",       64'(bus.ack),       64'(0));
        bus.req = '0;
        reset   = 1'b1;

        // Basic multiply: 0.5 * 3.0 = 1.5.
        op(0, 16'h0080, 16'h0300, 16'h0180, 1'b0);
        drain(LAT + 1);

        // Sign and floor truncation, issued back to back.
        op(0, 16'hFF00, 16'h0080, 16'hFF80, 1'b0);
        op(1, 16'h0001, 16'h0001, 16'h0000, 1'b0);
        op(2, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0);
        drain(LAT + 1);

        // Saturation at both ends. The last grant goes to 2, so the pointer returns to 0.
        op(1, 16'h7F00, 16'h0200, 16'h7FFF, 1'b1);
        op(2, 16'h8000, 16'h7F00, 16'h8000, 1'b1);
        drain(LAT + 1);

        // Round robin with all requesters active, then 101 starting from ptr=1.
        bus.req = 3'b111;
        for (int i = 0; i < 7; i++) begin
            rand_ops();
            tick();
        end
        bus.req = 3'b101;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            tick();
        end
        bus.req = '0;
        drain(LAT + 1);

        // Stall for two cycles with two operations in flight.
        rand_ops();
        bus.req = 3'b011;
        tick();
        tick();
        bus.req = 3'b111;
        clk_en  = 1'b0;
        tick();
        tick();
        clk_en  = 1'b1;
        bus.req = '0;
        drain(LAT + 2);

        // Random mixed traffic.
        for (int i = 0; i < 12; i++) begin
            rand_ops();
            bus.req = NREQ'($urandom_range(0, 7));
            clk_en  = ($urandom_range(0, 3) != 0);
            tick();
        end
        clk_en  = 1'b1;
        bus.req = '0;
        drain(LAT + 2);

        // Reset with two operations in flight and ptr=2.
        op(0, 16'h0100, 16'h0200, 16'h0200, 1'b0);
        op(1, 16'h0300, 16'h0100, 16'h0300, 1'b0);
        bus.req = 3'b111;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_res_valid", 64'(bus.res_valid), 64'(0));
        chk("arst_busy",      64'(bus.busy),      64'(0));
        chk("arst_res",       64'(bus.res),       64'(0));
        chk("arst_ack",       64'(bus.ack),       64'(0));
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) pin_v[i] = 1'b0;
        m_ptr = 0;
        last  = '0;
        tick();
        tick();
        reset   = 1'b1;
        bus.req = 3'b110;
        rand_ops();
        tick();
        tick();
        bus.req = '0;
        drain(LAT + 3);

        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
